// File: rtl/div_pkg.sv
// Shared definitions for the restoring-divider front-end.
package div_pkg;

    // Default operand/result width and WAIT-state abort limit.
    localparam int DIV_N       = 6;
    localparam int DIV_TIMEOUT = 31;

    // Issue FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ZERO  = 2'd3
    } div_state_t;

    // Quotient reported for divide-by-zero and timeout results (all ones).
    localparam logic [DIV_N-1:0] DIV_DZ_QUOT = '1;

    // Width of a counter that must reach tmo without wrapping.
    function automatic int unsigned wait_cnt_width(input int unsigned tmo);
        return (tmo > 0) ? $clog2(tmo + 1) : 1;
    endfunction

endpackage

// File: rtl/div_operand_fifo.sv
// Two-entry operand FIFO: valid/ready push side, strobe pop side.
module div_operand_fifo #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push_valid,
    output logic         o_push_ready,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_head_valid,
    output logic [W-1:0] o_head
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         r_live;
    logic         r_head_valid;
    logic         w_push;
    logic         w_pop;

    // Ready follows the pre-pop count, so a full FIFO never accepts a push
    // even in a cycle where it also pops. Held low while in reset.
    assign o_push_ready = r_live && (r_count != 2'd2);
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = i_pop && (r_count != 2'd0);
    assign o_head       = r_mem[r_rd_ptr];

    // The head is advertised one cycle after it lands. Every pop also fills
    // the result slot, which blocks the next issue for at least two cycles,
    // so this lagging flag never advertises an entry that was just popped.
    assign o_head_valid = r_head_valid;

    // Storage, wrapping 1-bit pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0]     <= '0;
            r_mem[1]     <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_live       <= 1'b0;
            r_head_valid <= 1'b0;
        end else begin
            r_live       <= 1'b1;
            r_head_valid <= (r_count != 2'd0);
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/div_issue_unit.sv
// Divider front-end: buffers operand pairs, screens divide-by-zero, issues
// start pulses, bounds the wait for done, and holds results for the consumer.
module div_issue_unit
    import div_pkg::*;
#(
    parameter int N       = DIV_N,
    parameter int TIMEOUT = DIV_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_dividend,
    input  logic [N-1:0] in_divisor,
    output logic         div_start,
    output logic [N-1:0] div_dividend,
    output logic [N-1:0] div_divisor,
    input  logic         div_done,
    input  logic [N-1:0] div_quotient,
    input  logic [N-1:0] div_remainder,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_quotient,
    output logic [N-1:0] out_remainder,
    output logic         out_dz,
    output logic         out_tmo
);

    localparam int unsigned    CW       = wait_cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT);

    logic [2*N-1:0] w_head;
    logic [N-1:0]   w_head_dividend;
    logic [N-1:0]   w_head_divisor;
    logic           w_head_valid;
    logic           w_timeout;
    logic           w_pop;

    div_state_t     r_state;
    logic [CW-1:0]  r_wait_cnt;
    logic           r_div_start;
    logic           r_out_valid;
    logic [N-1:0]   r_out_quotient;
    logic [N-1:0]   r_out_remainder;
    logic           r_out_dz;
    logic           r_out_tmo;

    div_operand_fifo #(
        .W (2*N)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst),
        .i_push_valid (in_valid),
        .o_push_ready (in_ready),
        .i_push_data  ({in_dividend, in_divisor}),
        .i_pop        (w_pop),
        .o_head_valid (w_head_valid),
        .o_head       (w_head)
    );

    assign w_head_dividend = w_head[2*N-1:N];
    assign w_head_divisor  = w_head[N-1:0];
    assign w_timeout       = (r_wait_cnt == TMO_LAST);

    // The head entry leaves the FIFO when its WAIT or ZERO handling finishes.
    assign w_pop = (r_state == S_ZERO) ||
                   ((r_state == S_WAIT) && (div_done || w_timeout));

    assign div_start     = r_div_start;
    assign div_dividend  = w_head_dividend;
    assign div_divisor   = w_head_divisor;
    assign out_valid     = r_out_valid;
    assign out_quotient  = r_out_quotient;
    assign out_remainder = r_out_remainder;
    assign out_dz        = r_out_dz;
    assign out_tmo       = r_out_tmo;

    // Issue FSM with wait counter and result slot; all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_wait_cnt      <= '0;
            r_div_start     <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_quotient  <= '0;
            r_out_remainder <= '0;
            r_out_dz        <= 1'b0;
            r_out_tmo       <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (w_head_valid && !r_out_valid) begin
                        if (w_head_divisor == '0) begin
                            r_state <= S_ZERO;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_div_start <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // done takes priority over a coincident timeout
                    if (div_done) begin
                        r_out_quotient  <= div_quotient;
                        r_out_remainder <= div_remainder;
                        r_out_dz        <= 1'b0;
                        r_out_tmo       <= 1'b0;
                        r_out_valid     <= 1'b1;
                        r_state         <= S_IDLE;
                    end else if (w_timeout) begin
                        r_out_quotient  <= '1;
                        r_out_remainder <= w_head_dividend;
                        r_out_dz        <= 1'b0;
                        r_out_tmo       <= 1'b1;
                        r_out_valid     <= 1'b1;
                        r_state         <= S_IDLE;
                    end else if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                S_ZERO: begin
                    r_out_quotient  <= '1;
                    r_out_remainder <= w_head_dividend;
                    r_out_dz        <= 1'b1;
                    r_out_tmo       <= 1'b0;
                    r_out_valid     <= 1'b1;
                    r_state         <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_unit.sv
// Bench for div_issue_unit: directed scenarios plus a randomized run against
// a transaction-level model of results in push order.
`timescale 1ns/1ps
module tb_div_issue_unit;

    localparam int N = 6;
    localparam int T = 31;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_dividend;
    logic [N-1:0] in_divisor;
    logic         div_start;
    logic [N-1:0] div_dividend;
    logic [N-1:0] div_divisor;
    logic         div_done;
    logic [N-1:0] div_quotient;
    logic [N-1:0] div_remainder;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_quotient;
    logic [N-1:0] out_remainder;
    logic         out_dz;
    logic         out_tmo;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         tmo;
    } res_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           lat;   // cycles from start to done; 0 = divider never answers
    } op_t;

    res_t exp_q[$];
    op_t  lat_q[$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n_starts = 0;
    int start_cyc = 0;
    int push_cyc = 0;
    int ov_rise_cyc = 0;
    int rdy_mode = 1;        // 0 never ready, 1 always ready, 2 random
    bit spur_req = 1'b0;
    bit abandon = 1'b0;

    div_issue_unit #(
        .N       (N),
        .TIMEOUT (T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_done      (div_done),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_dz        (out_dz),
        .out_tmo       (out_tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one pair, wait (bounded) for acceptance, and record its expected result.
    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input int lat);
        res_t e;
        @(negedge clk);
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        for (int i = 0; i < 300 && in_ready !== 1'b1; i++) @(negedge clk);
        if (in_ready !== 1'b1) begin
            check("push_accept", 0, 1);
            in_valid = 1'b0;
            return;
        end
        push_cyc = cyc + 1;
        if (b == 0) begin
            e = '{q: 6'h3f, r: a, dz: 1'b1, tmo: 1'b0};
        end else begin
            lat_q.push_back('{a: a, b: b, lat: lat});
            if (lat == 0) e = '{q: 6'h3f, r: a, dz: 1'b0, tmo: 1'b1};
            else          e = '{q: a / b, r: a % b, dz: 1'b0, tmo: 1'b0};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // Divider model: answers each start after the planned latency.
    initial begin : responder
        op_t cur;
        bit  pend = 1'b0;
        int  pend_cnt = 0;
        logic prev_start = 1'b0;
        div_done = 1'b0;
        div_quotient = '0;
        div_remainder = '0;
        forever begin
            @(negedge clk);
            div_done = 1'b0;
            if (spur_req) begin
                div_done      = 1'b1;
                div_quotient  = 6'h15;
                div_remainder = 6'h2a;
                spur_req      = 1'b0;
            end
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pend = 1'b0;
                    if (!abandon) check("op_hold", {div_dividend, div_divisor}, {cur.a, cur.b});
                    div_done      = 1'b1;
                    div_quotient  = cur.a / cur.b;
                    div_remainder = cur.a % cur.b;
                end
            end
            if (div_start === 1'b1) begin
                n_starts++;
                start_cyc = cyc;
                check("start_1cyc", prev_start, 0);
                if (lat_q.size() == 0) begin
                    check("start_unexpected", 1, 0);
                end else begin
                    cur = lat_q.pop_front();
                    check("op_dividend", div_dividend, cur.a);
                    check("op_divisor", div_divisor, cur.b);
                    if (cur.lat != 0) begin
                        pend     = 1'b1;
                        pend_cnt = cur.lat;
                    end
                end
            end
            prev_start = div_start;
        end
    end

    // Consumer: drives out_ready and scores each accepted result in order.
    initial begin : consumer
        res_t e;
        logic prev_ov = 1'b0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid === 1'b1 && prev_ov !== 1'b1) ov_rise_cyc = cyc;
            prev_ov = out_valid;
            if (rst === 1'b1 && out_valid === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_quotient", out_quotient, e.q);
                    check("out_remainder", out_remainder, e.r);
                    check("out_dz", out_dz, e.dz);
                    check("out_tmo", out_tmo, e.tmo);
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s0;
        logic [N-1:0] a, b;
        int lat;
        rst = 1'b0;
        in_valid = 1'b0;
        in_dividend = '0;
        in_divisor = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs",
              {in_ready, div_start, out_valid, out_dz, out_tmo,
               out_quotient, out_remainder, div_dividend, div_divisor}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // 1: 45/6 with done 20 cycles after start
        s0 = n_starts;
        push(6'd45, 6'd6, 20);
        drain("t1_drain");
        check("t1_starts", n_starts - s0, 1);
        check("t1_start_lat", start_cyc - push_cyc, 2);

        // 2: divide by zero never starts the divider
        s0 = n_starts;
        push(6'd13, 6'd0, 0);
        drain("t2_drain");
        check("t2_no_start", n_starts - s0, 0);
        check("t2_ov_lat", ov_rise_cyc - push_cyc, 3);

        // 3: backpressure fills the FIFO, then drains in order
        rdy_mode = 0;
        push(6'd50, 6'd7, 4);
        push(6'd33, 6'd5, 6);
        check("t3_full", in_ready, 0);
        push(6'd60, 6'd9, 3);
        repeat (5) @(negedge clk);
        check("t3_held_valid", out_valid, 1);
        check("t3_held_q", out_quotient, 7);
        check("t3_full_again", in_ready, 0);
        rdy_mode = 1;
        drain("t3_drain");

        // 4: divider never answers; then done exactly at the timeout cycle wins
        push(6'd20, 6'd5, 0);
        drain("t4_drain");
        check("t4_tmo_lat", ov_rise_cyc - start_cyc, T + 2);
        push(6'd40, 6'd3, T + 1);
        push(6'd41, 6'd63, 1);
        drain("t4b_drain");

        // 5: spurious done while idle
        repeat (2) @(negedge clk);
        s0 = n_starts;
        spur_req = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_no_out", out_valid, 0);
        check("t5_no_start", n_starts - s0, 0);

        // 6: reset during WAIT abandons the operation; late done ignored
        s0 = n_starts;
        push(6'd30, 6'd4, 25);
        for (int i = 0; i < 50 && n_starts == s0; i++) @(negedge clk);
        check("t6_started", n_starts - s0, 1);
        repeat (5) @(negedge clk);
        abandon = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("t6_rst_outputs",
              {in_ready, div_start, out_valid, out_dz, out_tmo,
               out_quotient, out_remainder, div_dividend, div_divisor}, 0);
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("t6_done_ignored", out_valid, 0);
        check("t6_in_ready", in_ready, 1);
        abandon = 1'b0;
        push(6'd17, 6'd0, 0);
        drain("t6_fifo_empty");

        // Randomized traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            a = 6'($urandom_range(0, 63));
            b = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            case ($urandom_range(0, 9))
                0:       lat = 0;
                1:       lat = T + 1;
                default: lat = $urandom_range(1, T);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(a, b, lat);
        end
        rdy_mode = 1;
        drain("rand_drain");
        check("rand_ops_consumed", lat_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
